// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: FSM state type, segment font table and font lookup for the scan controller
package seg7_scan_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    localparam logic [4:0] DASH  = 5'd16;
    localparam logic [4:0] BLANK = 5'd17;

    // Active-high {a,b,c,d,e,f,g}, bit 6 = a; entries 0..15 are hex glyphs.
    localparam logic [6:0] FONT [0:17] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
        7'h01, 7'h00
    };

    // Codes beyond the table decode to blank so every input has a defined glyph.
    function automatic logic [6:0] seg7_font(input logic [4:0] code);
        return (code <= BLANK) ? FONT[code] : FONT[BLANK];
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: value/command inputs and display outputs of the scan controller
//   val_i, load_i, hex_mode_i, blank_lz_i : command side (driven by master)
//   busy_o, ovf_o, seg_o, an_o            : status and pin side (driven by slave)
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_W      = 14
);
    logic [VAL_W-1:0]      val_i;
    logic                  load_i;
    logic                  hex_mode_i;
    logic                  blank_lz_i;
    logic                  busy_o;
    logic                  ovf_o;
    logic [6:0]            seg_o;
    logic [NUM_DIGITS-1:0] an_o;

    modport master (output val_i, load_i, hex_mode_i, blank_lz_i,
                    input  busy_o, ovf_o, seg_o, an_o);
    modport slave  (input  val_i, load_i, hex_mode_i, blank_lz_i,
                    output busy_o, ovf_o, seg_o, an_o);
endinterface

// File: rtl/seg7_scan_ctrl_bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per clock
//   clk, rst : clock, async active-high reset
//   start_i  : load val_i and begin a VAL_W-step conversion
//   val_i    : binary input
//   done_o   : high during the final step; bcd_o holds the result from the next cycle
//   bcd_o    : NUM_DIGITS packed BCD digits (truncated if the value does not fit)
module bin2bcd_seq #(
    parameter int VAL_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [VAL_W-1:0]        val_i,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] sh;
    logic [DW-1:0]    adj;
    logic [CW-1:0]    cnt;
    logic             run;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        assign adj[4*g +: 4] = (bcd_o[4*g +: 4] >= 4'd5) ? bcd_o[4*g +: 4] + 4'd3 : bcd_o[4*g +: 4];
    end

    // done_o marks the last step so the caller's SHIFT phase lasts exactly VAL_W cycles.
    assign done_o = run && cnt == CW'(VAL_W - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh    <= '0;
            bcd_o <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (start_i) begin
            sh    <= val_i;
            bcd_o <= '0;
            cnt   <= '0;
            run   <= 1'b1;
        end else if (run) begin
            sh    <= sh << 1;
            bcd_o <= (adj << 1) | DW'(sh[VAL_W-1]);
            cnt   <= cnt + 1'b1;
            run   <= !done_o;
        end
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: captures a value, converts it to decimal or hex digits and scans them
//   onto a shared 7-segment bus with one-hot anode drive
//   clk, rst : clock, async active-high reset
//   bus      : slave side of seg7_scan_ctrl_if (value/mode/blank in; busy/ovf/seg/an out)
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int VAL_W          = 14,
    parameter int CLK_HZ         = 125_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_ctrl_if.slave   bus
);
    localparam int DW   = 4 * NUM_DIGITS;
    localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV  = CLK_HZ / SCAN_HZ;
    localparam int PW   = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TERM = DIV - 1;
    localparam longint unsigned LIM = 10 ** NUM_DIGITS;

    state_t              state;
    logic [DW-1:0]       dig;
    logic [DW-1:0]       nib_q;
    logic [DW-1:0]       bcd;
    logic                hex_q;
    logic                ovf_q;
    logic                done;
    logic                start;
    logic                ovf_in;
    logic [VAL_W+DW-1:0] vx;
    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [DW-1:0]       upper;
    logic                lz;
    logic [4:0]          code;

    assign start = state == IDLE && bus.load_i && !bus.hex_mode_i;

    always_comb begin
        vx     = {{DW{1'b0}}, bus.val_i};
        ovf_in = bus.hex_mode_i ? (vx >> DW) != '0 : 64'(bus.val_i) >= LIM;
    end

    bin2bcd_seq #(.VAL_W(VAL_W), .NUM_DIGITS(NUM_DIGITS)) u_bcd (
        .clk    (clk),
        .rst    (rst),
        .start_i(start),
        .val_i  (bus.val_i),
        .done_o (done),
        .bcd_o  (bcd)
    );

    // Digits and ovf_o change together only at the end of FINISH, so the scan never
    // sees a half-built result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dig        <= '0;
            nib_q      <= '0;
            hex_q      <= 1'b0;
            ovf_q      <= 1'b0;
            bus.ovf_o  <= 1'b0;
            bus.busy_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.load_i) begin
                    nib_q      <= vx[DW-1:0];
                    hex_q      <= bus.hex_mode_i;
                    ovf_q      <= ovf_in;
                    bus.busy_o <= 1'b1;
                    state      <= bus.hex_mode_i ? FINISH : SHIFT;
                end
                SHIFT: if (done) state <= FINISH;
                FINISH: begin
                    dig        <= hex_q ? nib_q : bcd;
                    bus.ovf_o  <= ovf_q;
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Blanking is computed from live inputs each cycle so a blank_lz_i toggle shows at once.
    always_comb begin
        upper = dig >> (4 * idx);
        lz    = bus.blank_lz_i && idx != '0 && upper == '0;
        code  = bus.ovf_o ? DASH : lz ? BLANK : {1'b0, upper[3:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre       <= '0;
            idx       <= '0;
            bus.seg_o <= {7{SEG_ACTIVE_LOW}};
            bus.an_o  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
        end else begin
            pre       <= pre == PW'(TERM) ? '0 : pre + 1'b1;
            idx       <= pre != PW'(TERM) ? idx : idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            bus.seg_o <= seg7_font(code) ^ {7{SEG_ACTIVE_LOW}};
            bus.an_o  <= (NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl against an arithmetic display model
module tb_seg7_scan_ctrl;
    localparam int ND = 4;
    localparam int VW = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND), .VAL_W(VW)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .VAL_W(VW), .CLK_HZ(8), .SCAN_HZ(2),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cur_v = 0;
    bit cur_hex = 1'b0;

    logic [6:0] font [0:15] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic int pw(int base, int e);
        int p;
        p = 1;
        for (int i = 0; i < e; i++) p *= base;
        return p;
    endfunction

    function automatic bit exp_ovf();
        return cur_v >= pw(cur_hex ? 16 : 10, ND);
    endfunction

    // Glyph digit d should show for the displayed value, mode and live blank setting.
    function automatic logic [6:0] exp_seg(int d);
        int base;
        base = cur_hex ? 16 : 10;
        if (exp_ovf()) return 7'h01;
        if (bus.blank_lz_i && d > 0 && cur_v < pw(base, d)) return 7'h00;
        return font[(cur_v / pw(base, d)) % base];
    endfunction

    function automatic int active_digit();
        for (int i = 0; i < ND; i++) if (bus.an_o[i] == 1'b0) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_scan(input string tag);
        int d;
        for (int c = 0; c < 4 * ND + 2; c++) begin
            tick();
            n_cmp++;
            if ($countones(~bus.an_o) != 1) begin
                n_bad++;
                $display("FAIL %s onehot: an_o=%b, need exactly one low", tag, bus.an_o);
            end else begin
                d = active_digit();
                n_cmp++;
                if (bus.seg_o !== exp_seg(d)) begin
                    n_bad++;
                    $display("FAIL %s digit%0d: seg_o=%h expected %h", tag, d, bus.seg_o, exp_seg(d));
                end
            end
        end
        n_cmp++;
        if (bus.ovf_o !== exp_ovf()) begin
            n_bad++;
            $display("FAIL %s ovf: ovf_o=%b expected %b", tag, bus.ovf_o, exp_ovf());
        end
    endtask

    // Loads a value, checks busy length and the exact edge where new glyphs appear.
    task automatic load_val(input int v, input bit hex, input bit blz, input string tag);
        logic [6:0] old_seg [0:ND-1];
        int lat, busy_n, d;
        bus.blank_lz_i = blz;
        tick();
        for (int i = 0; i < ND; i++) old_seg[i] = exp_seg(i);
        bus.val_i = VW'(v);
        bus.hex_mode_i = hex;
        bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
        cur_v = v;
        cur_hex = hex;
        lat = hex ? 2 : VW + 2;
        busy_n = bus.busy_o ? 1 : 0;
        for (int c = 1; c <= lat; c++) begin
            tick();
            if (c < lat && bus.busy_o) busy_n++;
            d = active_digit();
            if (c == lat - 1) begin
                n_cmp++;
                if (bus.seg_o !== old_seg[d]) begin
                    n_bad++;
                    $display("FAIL %s early digit%0d: seg_o=%h expected old %h", tag, d, bus.seg_o, old_seg[d]);
                end
            end
            if (c == lat) begin
                n_cmp++;
                if (bus.seg_o !== exp_seg(d)) begin
                    n_bad++;
                    $display("FAIL %s latency digit%0d: seg_o=%h expected %h", tag, d, bus.seg_o, exp_seg(d));
                end
            end
        end
        n_cmp++;
        if (busy_n != lat - 1) begin
            n_bad++;
            $display("FAIL %s busy_len: %0d cycles expected %0d", tag, busy_n, lat - 1);
        end
    endtask

    task automatic check_idle_pins(input string tag);
        n_cmp++;
        if (bus.an_o !== 4'b1111 || bus.seg_o !== 7'h00 || bus.busy_o !== 1'b0 || bus.ovf_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: an=%b seg=%h busy=%b ovf=%b expected 1111 00 0 0",
                     tag, bus.an_o, bus.seg_o, bus.busy_o, bus.ovf_o);
        end
    endtask

    task automatic check_first_slot(input string tag);
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.an_o !== 4'b1110 || bus.seg_o !== 7'h7E) begin
            n_bad++;
            $display("FAIL %s first_slot: an=%b seg=%h expected 1110 7e", tag, bus.an_o, bus.seg_o);
        end
    endtask

    task automatic test_reset();
        bus.val_i = '0;
        bus.load_i = 1'b0;
        bus.hex_mode_i = 1'b0;
        bus.blank_lz_i = 1'b0;
        #2 rst = 1'b1;
        #1 check_idle_pins("reset");
        cur_v = 0;
        cur_hex = 1'b0;
        repeat (2) tick();
        check_first_slot("reset");
        check_scan("reset_scan");
    endtask

    task automatic test_decimal();
        load_val(1234, 1'b0, 1'b0, "dec1234");
        check_scan("dec1234_scan");
    endtask

    task automatic test_hex();
        load_val(16'h2A5F, 1'b1, 1'b0, "hex2a5f");
        check_scan("hex2a5f_scan");
    endtask

    task automatic test_blank();
        load_val(7, 1'b0, 1'b1, "blank7");
        check_scan("blank7_scan");
        load_val(0, 1'b0, 1'b1, "blank0");
        check_scan("blank0_scan");
        load_val(7, 1'b0, 1'b0, "noblank7");
        check_scan("noblank7_scan");
        bus.blank_lz_i = 1'b1;
        check_scan("toggle_blank_scan");
        bus.blank_lz_i = 1'b0;
    endtask

    task automatic test_overflow();
        load_val(10000, 1'b0, 1'b0, "ovf10000");
        check_scan("ovf10000_scan");
        load_val(9999, 1'b0, 1'b0, "dec9999");
        check_scan("dec9999_scan");
        load_val(10000, 1'b0, 1'b1, "ovf_blank");
        check_scan("ovf_blank_scan");
    endtask

    task automatic test_reset_mid();
        bus.val_i = VW'(1234);
        bus.hex_mode_i = 1'b0;
        bus.blank_lz_i = 1'b0;
        bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1 check_idle_pins("reset_mid");
        cur_v = 0;
        cur_hex = 1'b0;
        check_first_slot("reset_mid");
        check_scan("reset_mid_scan");
    endtask

    task automatic test_back_to_back();
        int busy_n;
        bus.val_i = VW'(1234);
        bus.hex_mode_i = 1'b0;
        bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
        busy_n = bus.busy_o ? 1 : 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                bus.val_i = VW'(42);
                bus.load_i = 1'b1;
            end
            tick();
            bus.load_i = 1'b0;
            if (bus.busy_o) busy_n++;
        end
        cur_v = 1234;
        cur_hex = 1'b0;
        n_cmp++;
        if (busy_n != VW + 1) begin
            n_bad++;
            $display("FAIL ignore_load busy_len: %0d cycles expected %0d", busy_n, VW + 1);
        end
        check_scan("ignore_load_scan");
    endtask

    task automatic test_random();
        int v;
        bit h, b;
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, (1 << VW) - 1));
            h = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            load_val(v, h, b, "random");
            check_scan("random_scan");
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decimal();
        test_hex();
        test_blank();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
